// File: rtl/xif_alu_coproc.sv
// CV-X-IF ALU coprocessor: decodes custom ALU ops, holds up to DEPTH in-flight results,
// and retires them in issue order once committed; killed entries are discarded.
module xif_alu_coproc #(
   parameter int          X_NUM_RS   = 2,
   parameter int          X_ID_WIDTH = 4,
   parameter int          XLEN       = 32,
   parameter int          DEPTH      = 4,
   parameter logic [6:0]  OPCODE     = 7'h0b
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      issue_valid,
   output logic                      issue_ready,
   input  logic [31:0]               issue_req_instr,
   input  logic [X_ID_WIDTH-1:0]     issue_req_id,
   input  logic [X_NUM_RS*XLEN-1:0]  issue_req_rs,
   input  logic [X_NUM_RS-1:0]       issue_req_rs_valid,
   output logic                      issue_resp_accept,
   output logic                      issue_resp_writeback,
   input  logic                      commit_valid,
   input  logic [X_ID_WIDTH-1:0]     commit_id,
   input  logic                      commit_kill,
   output logic                      result_valid,
   input  logic                      result_ready,
   output logic [X_ID_WIDTH-1:0]     result_id,
   output logic [XLEN-1:0]           result_data,
   output logic [4:0]                result_rd,
   output logic                      result_we,
   output logic [$clog2(DEPTH):0]    occupancy
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0]     FULL  = (PW+1)'(DEPTH);
   localparam logic [XLEN-1:0] MAGIC = XLEN'(32'hDEADBEEF);

   typedef enum logic [1:0] {FREE, WAIT_COMMIT, COMMITTED, KILLED} ent_st_t;

   ent_st_t               r_st   [DEPTH];
   logic [X_ID_WIDTH-1:0] r_id   [DEPTH];
   logic [XLEN-1:0]       r_data [DEPTH];
   logic [4:0]            r_rd   [DEPTH];
   logic [PW-1:0]         r_head, r_tail;
   logic [PW:0]           r_cnt;

   logic [XLEN-1:0] w_rs1, w_rs2, w_res;
   logic            w_ours, w_push, w_pop, w_unused;
   ent_st_t         w_head_st;

   assign w_rs1    = issue_req_rs[XLEN-1:0];
   assign w_rs2    = issue_req_rs[2*XLEN-1:XLEN];
   assign w_unused = ^issue_req_instr[31:15];

   always_comb begin
      w_ours = 1'b0;
      w_res  = '0;
      if (issue_req_instr[6:0] == OPCODE) begin
         case (issue_req_instr[14:12])
            3'b000:  begin w_ours = 1'b1; w_res = w_rs1 + w_rs2; end
            3'b001:  begin w_ours = 1'b1; w_res = w_rs1 ^ w_rs2; end
            3'b010:  begin w_ours = 1'b1; w_res = MAGIC; end
            3'b011:  begin w_ours = 1'b1; w_res = (w_rs1 < w_rs2) ? w_rs1 : w_rs2; end
            default: begin w_ours = 1'b0; w_res = '0; end
         endcase
      end
   end

   assign issue_ready          = (r_cnt != FULL);
   assign issue_resp_accept    = issue_valid && w_ours && (issue_req_rs_valid[1:0] == 2'b11);
   assign issue_resp_writeback = issue_resp_accept;
   assign w_push               = issue_resp_accept && issue_ready;

   // Head is presented straight from its entry; killed heads drain silently.
   assign w_head_st    = r_st[r_head];
   assign result_valid = (w_head_st == COMMITTED);
   assign result_id    = result_valid ? r_id[r_head]   : '0;
   assign result_data  = result_valid ? r_data[r_head] : '0;
   assign result_rd    = result_valid ? r_rd[r_head]   : '0;
   assign result_we    = result_valid && (r_rd[r_head] != 5'd0);
   assign w_pop        = (result_valid && result_ready) || (w_head_st == KILLED);
   assign occupancy    = r_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_st[i]   <= FREE;
            r_id[i]   <= '0;
            r_data[i] <= '0;
            r_rd[i]   <= '0;
         end
         r_head <= '0;
         r_tail <= '0;
         r_cnt  <= '0;
      end else begin
         // Only entries already waiting can match, so a same-cycle issue is never hit.
         for (int i = 0; i < DEPTH; i++) begin
            if (commit_valid && r_st[i] == WAIT_COMMIT && r_id[i] == commit_id)
               r_st[i] <= commit_kill ? KILLED : COMMITTED;
         end
         if (w_pop) begin
            r_st[r_head] <= FREE;
            r_head       <= r_head + PW'(1);
         end
         if (w_push) begin
            r_st[r_tail]   <= WAIT_COMMIT;
            r_id[r_tail]   <= issue_req_id;
            r_data[r_tail] <= w_res;
            r_rd[r_tail]   <= issue_req_instr[11:7];
            r_tail         <= r_tail + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_xif_alu_coproc.sv
// Directed bench for xif_alu_coproc: scoreboard of in-order results, killed IDs removed.
module tb_xif_alu_coproc;

   localparam logic [6:0] OP = 7'h0b;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        issue_valid = 1'b0;
   logic        issue_ready;
   logic [31:0] issue_req_instr = '0;
   logic [3:0]  issue_req_id = '0;
   logic [63:0] issue_req_rs = '0;
   logic [1:0]  issue_req_rs_valid = '0;
   logic        issue_resp_accept, issue_resp_writeback;
   logic        commit_valid = 1'b0;
   logic [3:0]  commit_id = '0;
   logic        commit_kill = 1'b0;
   logic        result_valid;
   logic        result_ready = 1'b1;
   logic [3:0]  result_id;
   logic [31:0] result_data;
   logic [4:0]  result_rd;
   logic        result_we;
   logic [2:0]  occupancy;

   xif_alu_coproc dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_req_instr(issue_req_instr), .issue_req_id(issue_req_id),
      .issue_req_rs(issue_req_rs), .issue_req_rs_valid(issue_req_rs_valid),
      .issue_resp_accept(issue_resp_accept), .issue_resp_writeback(issue_resp_writeback),
      .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
      .result_valid(result_valid), .result_ready(result_ready),
      .result_id(result_id), .result_data(result_data),
      .result_rd(result_rd), .result_we(result_we),
      .occupancy(occupancy)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [3:0]  id;
      logic [31:0] data;
      logic [4:0]  rd;
      logic        we;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   nres   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, b);
      case (f3)
         3'b000:  return a + b;
         3'b001:  return a ^ b;
         3'b010:  return 32'hDEADBEEF;
         default: return (a < b) ? a : b;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk_i); #1;
   endtask

   task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [3:0] id, input logic [31:0] a, input logic [31:0] b,
                        input bit exp_acc, input bit taken);
      exp_t e;
      issue_valid        = 1'b1;
      issue_req_instr    = {7'd0, 5'd2, 5'd1, f3, rd, op};
      issue_req_id       = id;
      issue_req_rs       = {b, a};
      issue_req_rs_valid = 2'b11;
      @(negedge clk_i);
      chk("accept", issue_resp_accept, exp_acc);
      chk("writeback", issue_resp_writeback, exp_acc);
      if (taken) begin
         e.id = id; e.data = model(f3, a, b); e.rd = rd; e.we = (rd != 5'd0);
         sb.push_back(e);
      end
      tick();
      issue_valid = 1'b0;
   endtask

   task automatic commit(input logic [3:0] id, input bit kill);
      commit_valid = 1'b1;
      commit_id    = id;
      commit_kill  = kill;
      tick();
      commit_valid = 1'b0;
      commit_kill  = 1'b0;
   endtask

   task automatic kill_model(input logic [3:0] id);
      for (int i = 0; i < sb.size(); i++)
         if (sb[i].id == id) begin
            sb.delete(i);
            break;
         end
   endtask

   // Every accepted result is popped from the scoreboard and compared in order.
   always @(negedge clk_i) begin
      if (!rst_i && result_valid === 1'b1 && result_ready === 1'b1) begin
         nres++;
         if (sb.size() == 0) begin
            chk("unexpected_result_id", {60'd0, result_id}, 64'hFFFF);
         end else begin
            mon_e = sb.pop_front();
            chk("res_id", result_id, mon_e.id);
            chk("res_data", result_data, mon_e.data);
            chk("res_rd", result_rd, mon_e.rd);
            chk("res_we", result_we, mon_e.we);
         end
      end
   end

   initial begin
      // reset state
      repeat (3) tick();
      chk("rst_valid", result_valid, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_id", result_id, 0);
      chk("rst_data", result_data, 0);
      chk("rst_we", result_we, 0);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("rst_ready", issue_ready, 1);
      tick();

      // ADD with minimum latency
      issue(OP, 3'b000, 5'd3, 4'd2, 32'd5, 32'd7, 1, 1);
      commit_valid = 1'b1; commit_id = 4'd2; commit_kill = 1'b0;
      @(negedge clk_i);
      chk("lat_early", result_valid, 0);
      tick();
      commit_valid = 1'b0;
      @(negedge clk_i);
      chk("lat_valid", result_valid, 1);
      chk("add_data", result_data, 32'd12);
      tick();

      // MAGIC to x0, then rejected encodings
      issue(OP, 3'b010, 5'd0, 4'd5, 32'd1, 32'd2, 1, 1);
      commit(4'd5, 0);
      tick();
      issue(OP, 3'b111, 5'd4, 4'd6, 32'd1, 32'd2, 0, 0);
      issue(7'h33, 3'b000, 5'd4, 4'd6, 32'd1, 32'd2, 0, 0);
      chk("reject_occ", occupancy, 0);

      // fill, then a fifth request is refused
      for (int i = 0; i < 4; i++)
         issue(OP, 3'b000, 5'(i + 8), 4'(i), 32'(i * 100), 32'd1, 1, 1);
      chk("full_occ", occupancy, 4);
      chk("full_ready", issue_ready, 0);
      issue(OP, 3'b001, 5'd9, 4'd4, 32'd3, 32'd3, 1, 0);
      chk("full_occ2", occupancy, 4);
      commit(4'd0, 0);
      @(negedge clk_i);
      chk("full_pop_ready", issue_ready, 0);
      tick();
      chk("after_pop_ready", issue_ready, 1);
      chk("after_pop_occ", occupancy, 3);
      commit(4'd1, 0);
      commit(4'd2, 0);
      commit(4'd3, 0);
      repeat (2) tick();
      chk("drain_occ", occupancy, 0);

      // kill and out-of-order commit
      issue(OP, 3'b000, 5'd1, 4'd1, 32'd10, 32'd1, 1, 1);
      issue(OP, 3'b001, 5'd2, 4'd2, 32'hFF, 32'h0F, 1, 1);
      issue(OP, 3'b011, 5'd3, 4'd3, 32'd9, 32'd4, 1, 1);
      commit(4'd1, 1);
      kill_model(4'd1);
      commit(4'd3, 0);
      commit(4'd2, 0);
      repeat (3) tick();
      chk("kill_occ", occupancy, 0);

      // backpressure holds payload
      result_ready = 1'b0;
      issue(OP, 3'b001, 5'd7, 4'd7, 32'h0000F0F0, 32'h00000FF0, 1, 1);
      commit_valid = 1'b1; commit_id = 4'd7; commit_kill = 1'b0;
      issue(OP, 3'b011, 5'd8, 4'd8, 32'd100, 32'd37, 1, 1);
      commit_valid = 1'b0;
      commit(4'd8, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         chk("stall_valid", result_valid, 1);
         chk("stall_id", result_id, 4'd7);
         chk("stall_data", result_data, 32'h0000FF00);
         tick();
      end
      chk("stall_occ", occupancy, 2);
      result_ready = 1'b1;
      tick();
      chk("release_occ", occupancy, 1);
      tick();
      chk("release_occ2", occupancy, 0);

      // asynchronous reset mid-flight
      result_ready = 1'b0;
      issue(OP, 3'b000, 5'd5, 4'd9, 32'd1, 32'd1, 1, 1);
      issue(OP, 3'b000, 5'd5, 4'd10, 32'd2, 32'd1, 1, 1);
      issue(OP, 3'b000, 5'd5, 4'd11, 32'd3, 32'd1, 1, 1);
      commit(4'd9, 0);
      chk("pre_rst_valid", result_valid, 1);
      chk("pre_rst_occ", occupancy, 3);
      rst_i = 1'b1;
      #1;
      chk("midrst_valid", result_valid, 0);
      chk("midrst_occ", occupancy, 0);
      sb.delete();
      tick();
      rst_i = 1'b0;
      result_ready = 1'b1;
      commit(4'd10, 0);
      commit(4'd11, 0);
      repeat (2) tick();
      chk("post_rst_valid", result_valid, 0);
      chk("post_rst_occ", occupancy, 0);
      chk("post_rst_ready", issue_ready, 1);

      chk("result_count", nres, 10);
      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
